// File: rtl/ff_d_pkg.sv
// Shared constants for the ff_d storage cell family.
package ff_d_pkg;

   // Default stored width when ff_d is used as a single state bit.
   localparam int FF_D_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/ff_d_cell.sv
// One D flip-flop bit with synchronous active-low clear (highest priority)
// and synchronous active-low preset.
module ff_d_cell #(
   parameter logic INIT = 1'b0
) (
   input  logic clk,
   input  logic d,
   input  logic preset,
   input  logic clear,
   output logic q,
   output logic qNot
);

   // Declaration value only sets the simulation power-up state.
   logic q_reg = INIT;

   always_ff @(posedge clk) begin
      if (!clear) begin
         q_reg <= 1'b0;
      end else if (!preset) begin
         q_reg <= 1'b1;
      end else begin
         q_reg <= d;
      end
   end

   assign q    = q_reg;
   assign qNot = ~q_reg;

endmodule

// File: rtl/ff_d.sv
// WIDTH-bit D register built from ff_d_cell bits sharing clk, preset and clear.
module ff_d
   import ff_d_pkg::*;
#(
   parameter int               WIDTH = FF_D_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   input  logic             preset,
   input  logic             clear,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qNot
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         ff_d_cell #(
            .INIT (INIT[gi])
         ) u_cell (
            .clk    (clk),
            .d      (d[gi]),
            .preset (preset),
            .clear  (clear),
            .q      (q[gi]),
            .qNot   (qNot[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_ff_d.sv
// Directed bench for ff_d at WIDTH=1 and WIDTH=8 with a per-edge reference model.
module tb_ff_d;

   logic       clk = 1'b0;
   logic       preset;
   logic       clear;
   logic       d1;
   logic [7:0] d8;
   logic       q1, qn1;
   logic [7:0] q8, qn8;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   ff_d #(.WIDTH(1)) dut1 (
      .clk    (clk),
      .d      (d1),
      .preset (preset),
      .clear  (clear),
      .q      (q1),
      .qNot   (qn1)
   );

   ff_d #(.WIDTH(8)) dut8 (
      .clk    (clk),
      .d      (d8),
      .preset (preset),
      .clear  (clear),
      .q      (q8),
      .qNot   (qn8)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: what q must hold after each rising edge.
   logic       e1;
   logic [7:0] e8;
   always @(posedge clk) begin
      if (clear === 1'b0) begin
         e1 = 1'b0;
         e8 = 8'h00;
      end else if (preset === 1'b0) begin
         e1 = 1'b1;
         e8 = 8'hFF;
      end else begin
         e1 = d1;
         e8 = d8;
      end
      #1;
      chk("model_q1",   {7'b0, q1},  {7'b0, e1});
      chk("model_qn1",  {7'b0, qn1}, {7'b0, ~e1});
      chk("model_q8",   q8,  e8);
      chk("model_qn8",  qn8, ~e8);
   end

   // Apply inputs on the falling edge, check literal q just after the next rising edge.
   task automatic step(input string name, input logic p, input logic c,
                       input logic dv1, input logic [7:0] dv8,
                       input logic ex1, input logic [7:0] ex8, input bit glitch);
      preset = p;
      clear  = c;
      d1     = dv1;
      d8     = dv8;
      @(posedge clk);
      #1;
      chk({name, "_q1"}, {7'b0, q1}, {7'b0, ex1});
      chk({name, "_q8"}, q8, ex8);
      $display("t=%0t %s preset=%b clear=%b d1=%b d8=%h -> q1=%b qn1=%b q8=%h qn8=%h",
               $time, name, p, c, dv1, dv8, q1, qn1, q8, qn8);
      if (glitch) begin
         // Disturb data mid-period; the stored value must not move.
         #4;
         d1 = ~d1;
         d8 = ~d8;
         #2;
         chk({name, "_hold_q1"}, {7'b0, q1}, {7'b0, ex1});
         chk({name, "_hold_q8"}, q8, ex8);
         chk({name, "_hold_qn1"}, {7'b0, qn1}, {7'b0, ~ex1});
      end
      @(negedge clk);
   endtask

   initial begin
      preset = 1'b1;
      clear  = 1'b1;
      d1     = 1'b0;
      d8     = 8'h00;
      #1;
      chk("init_q1",  {7'b0, q1},  8'h00);
      chk("init_qn1", {7'b0, qn1}, 8'h01);
      chk("init_q8",  q8, 8'h00);
      #0;
      preset = 1'b0;
      clear  = 1'b0;
      // {preset,clear,d}
      step("pc000", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
      step("pc001", 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
      step("pc010", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
      step("pc011", 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'hFF, 1'b0);
      step("pc100", 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
      step("pc101", 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 8'h00, 1'b0);
      step("pc110", 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0);
      step("pc111", 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 8'hC3, 1'b0);
      step("tog0",  1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b1);
      step("tog1",  1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1);
      step("tog2",  1'b1, 1'b1, 1'b0, 8'h0F, 1'b0, 8'h0F, 1'b1);
      step("hold_pre0", 1'b0, 1'b1, 1'b0, 8'h12, 1'b1, 8'hFF, 1'b1);
      step("hold_pre1", 1'b0, 1'b1, 1'b0, 8'h34, 1'b1, 8'hFF, 1'b0);
      step("rel_pre",   1'b1, 1'b1, 1'b0, 8'h56, 1'b0, 8'h56, 1'b0);
      step("w8_load",   1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0);
      step("w8_clear",  1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
      step("w8_clear2", 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
      step("w8_preset", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
      step("w8_resume", 1'b1, 1'b1, 1'b0, 8'h69, 1'b0, 8'h69, 1'b0);
      #5;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
